// File: rtl/sensor_cfg_sequencer.sv
// Walks a {dev, reg, val} configuration table and issues I2C register writes, with delay entries and retries.
// Optional macro CFG_READBACK_EN: after each write, read the register back and verify it.
module sensor_cfg_sequencer #(
    parameter int          LUT_AW    = 10,
    parameter logic [23:0] PWR_WAIT  = 24'd1_000_000,
    parameter logic [15:0] DLY_UNIT  = 16'd50_000,
    parameter int          MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [LUT_AW-1:0] lut_index,
    input  logic [31:0]       lut_data,
    output logic              i2c_req,
    output logic              i2c_rd,
    output logic [7:0]        i2c_dev,
    output logic [15:0]       i2c_reg,
    output logic [7:0]        i2c_wdata,
    input  logic              i2c_done,
    input  logic              i2c_nack,
    input  logic [7:0]        i2c_rdata,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [LUT_AW-1:0] err_index
);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {
        IDLE, PWR, FETCH, ISSUE, WAIT,
`ifdef CFG_READBACK_EN
        RB_ISSUE, RB_WAIT,
`endif
        DELAY, NEXT, DONE, FAIL
    } state_t;

    state_t            state_reg;
    logic [23:0]       pwr_cnt_reg;
    logic [31:0]       dly_cnt_reg;
    logic [RW-1:0]     retry_cnt_reg;
    logic [31:0]       word_reg;
    logic              fetched_reg;
    logic [LUT_AW-1:0] lut_index_reg;
    logic [LUT_AW-1:0] err_index_reg;
    logic              i2c_req_reg;
    logic              i2c_rd_reg;
    logic [7:0]        i2c_dev_reg;
    logic [15:0]       i2c_reg_reg;
    logic [7:0]        i2c_wdata_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              err_reg;

    logic [31:0] dly_total;
    logic        retry_exhausted;

    assign dly_total       = 32'(word_reg[23:8]) * 32'(DLY_UNIT);
    assign retry_exhausted = (retry_cnt_reg == RW'(MAX_RETRY));

`ifndef CFG_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^i2c_rdata;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            pwr_cnt_reg   <= '0;
            dly_cnt_reg   <= '0;
            retry_cnt_reg <= '0;
            word_reg      <= '0;
            fetched_reg   <= 1'b0;
            lut_index_reg <= '0;
            err_index_reg <= '0;
            i2c_req_reg   <= 1'b0;
            i2c_rd_reg    <= 1'b0;
            i2c_dev_reg   <= '0;
            i2c_reg_reg   <= '0;
            i2c_wdata_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    busy_reg      <= 1'b1;
                    pwr_cnt_reg   <= '0;
                    lut_index_reg <= '0;
                    done_reg      <= 1'b0;
                    err_reg       <= 1'b0;
                    state_reg     <= PWR;
                end
                PWR: begin
                    if (pwr_cnt_reg + 24'd1 >= PWR_WAIT) begin
                        pwr_cnt_reg   <= '0;
                        fetched_reg   <= 1'b0;
                        retry_cnt_reg <= '0;
                        state_reg     <= FETCH;
                    end else begin
                        pwr_cnt_reg <= pwr_cnt_reg + 24'd1;
                    end
                end
                // First cycle captures the table word, second cycle decodes the captured copy.
                FETCH: begin
                    if (!fetched_reg) begin
                        word_reg    <= lut_data;
                        fetched_reg <= 1'b1;
                    end else begin
                        fetched_reg <= 1'b0;
                        case (word_reg[31:24])
                            8'hFF: begin
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= DONE;
                            end
                            8'hFE: begin
                                if (word_reg[23:8] == 16'd0) begin
                                    state_reg <= NEXT;
                                end else begin
                                    dly_cnt_reg <= dly_total;
                                    state_reg   <= DELAY;
                                end
                            end
                            8'h00: begin
                                err_reg       <= 1'b1;
                                err_index_reg <= lut_index_reg;
                                busy_reg      <= 1'b0;
                                state_reg     <= FAIL;
                            end
                            default: begin
                                i2c_dev_reg   <= word_reg[31:24];
                                i2c_reg_reg   <= word_reg[23:8];
                                i2c_wdata_reg <= word_reg[7:0];
                                i2c_rd_reg    <= 1'b0;
                                state_reg     <= ISSUE;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    i2c_req_reg <= 1'b1;
                    i2c_rd_reg  <= 1'b0;
                    state_reg   <= WAIT;
                end
                WAIT: begin
                    if (i2c_done) begin
                        i2c_req_reg <= 1'b0;
                        if (i2c_nack) begin
                            if (retry_exhausted) begin
                                err_reg       <= 1'b1;
                                err_index_reg <= lut_index_reg;
                                busy_reg      <= 1'b0;
                                state_reg     <= FAIL;
                            end else begin
                                retry_cnt_reg <= retry_cnt_reg + RW'(1);
                                state_reg     <= ISSUE;
                            end
                        end else begin
`ifdef CFG_READBACK_EN
                            state_reg <= RB_ISSUE;
`else
                            state_reg <= NEXT;
`endif
                        end
                    end
                end
`ifdef CFG_READBACK_EN
                RB_ISSUE: begin
                    i2c_req_reg <= 1'b1;
                    i2c_rd_reg  <= 1'b1;
                    state_reg   <= RB_WAIT;
                end
                RB_WAIT: begin
                    if (i2c_done) begin
                        i2c_req_reg <= 1'b0;
                        i2c_rd_reg  <= 1'b0;
                        if (i2c_nack || (i2c_rdata != i2c_wdata_reg)) begin
                            if (retry_exhausted) begin
                                err_reg       <= 1'b1;
                                err_index_reg <= lut_index_reg;
                                busy_reg      <= 1'b0;
                                state_reg     <= FAIL;
                            end else begin
                                retry_cnt_reg <= retry_cnt_reg + RW'(1);
                                state_reg     <= ISSUE;
                            end
                        end else begin
                            state_reg <= NEXT;
                        end
                    end
                end
`endif
                DELAY: begin
                    if (dly_cnt_reg <= 32'd1) begin
                        dly_cnt_reg <= '0;
                        state_reg   <= NEXT;
                    end else begin
                        dly_cnt_reg <= dly_cnt_reg - 32'd1;
                    end
                end
                // An all-ones index means the table ran out without a terminator.
                NEXT: begin
                    if (&lut_index_reg) begin
                        err_reg       <= 1'b1;
                        err_index_reg <= lut_index_reg;
                        busy_reg      <= 1'b0;
                        state_reg     <= FAIL;
                    end else begin
                        lut_index_reg <= lut_index_reg + LUT_AW'(1);
                        retry_cnt_reg <= '0;
                        state_reg     <= FETCH;
                    end
                end
                DONE, FAIL: begin
                    if (start) begin
                        lut_index_reg <= '0;
                        done_reg      <= 1'b0;
                        err_reg       <= 1'b0;
                        busy_reg      <= 1'b1;
                        pwr_cnt_reg   <= '0;
                        state_reg     <= PWR;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign lut_index = lut_index_reg;
    assign err_index = err_index_reg;
    assign i2c_req   = i2c_req_reg;
    assign i2c_rd    = i2c_rd_reg;
    assign i2c_dev   = i2c_dev_reg;
    assign i2c_reg   = i2c_reg_reg;
    assign i2c_wdata = i2c_wdata_reg;
    assign busy      = busy_reg;
    assign cfg_done  = done_reg;
    assign cfg_err   = err_reg;
endmodule

// File: doc/sensor_cfg_sequencer.md
SENSOR_CFG_SEQUENCER -- requirements
Module: sensor_cfg_sequencer

Interface
REQ-001 The module SHALL have parameter LUT_AW, default 10, meaning configuration-table index width.
REQ-002 The module SHALL have parameter PWR_WAIT, default 24'd1_000_000, meaning clk cycles waited after reset/start before the first write.
REQ-003 The module SHALL have parameter DLY_UNIT, default 16'd50_000, meaning clk cycles per delay-entry count.
REQ-004 The module SHALL have parameter MAX_RETRY, default 3, meaning extra attempts per entry after a failed transfer.
REQ-005 The module SHALL have port clk, input, 1, the single clock.
REQ-006 The module SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-007 The module SHALL have port start, input, 1, pulse that requests a full (re)configuration.
REQ-008 The module SHALL have port lut_index, output, LUT_AW, the table address.
REQ-009 The module SHALL have port lut_data, input, 32, table word {dev[31:24], reg[23:8], val[7:0]}.
REQ-010 The module SHALL have port i2c_req, output, 1, transfer request.
REQ-011 The module SHALL have port i2c_rd, output, 1, 1 = read transfer.
REQ-012 The module SHALL have ports i2c_dev (output, 8), i2c_reg (output, 16) and i2c_wdata (output, 8), the transfer fields.
REQ-013 The module SHALL have port i2c_done, input, 1, one-cycle transfer-complete pulse.
REQ-014 The module SHALL have port i2c_nack, input, 1, valid with i2c_done; 1 = transfer failed.
REQ-015 The module SHALL have port i2c_rdata, input, 8, read data, valid with i2c_done.
REQ-016 The module SHALL have ports busy, cfg_done and cfg_err (outputs, 1 each), the status flags.
REQ-017 The module SHALL have port err_index, output, LUT_AW, the index of the failing entry.

Function
REQ-018 The FSM SHALL use states IDLE, PWR, FETCH, ISSUE, WAIT, RB_ISSUE, RB_WAIT, DELAY, NEXT, DONE and FAIL.
REQ-019 On reset exit the FSM SHALL go to PWR; from IDLE, DONE or FAIL, start SHALL clear lut_index to 0 and cfg_done/cfg_err, then go to PWR.
REQ-020 PWR SHALL count PWR_WAIT cycles, then go to FETCH.
REQ-021 FETCH SHALL register lut_data in one cycle (lut_data is combinational from lut_index) and decode the registered word.
REQ-022 dev = 8'hFF SHALL go to DONE: cfg_done=1, busy=0.
REQ-023 dev = 8'hFE SHALL be a delay entry: go to DELAY and wait reg[15:0]*DLY_UNIT cycles; a count of 0 SHALL wait 0 cycles.
REQ-024 dev = 8'h00 SHALL be treated as an unprogrammed entry and go to FAIL.
REQ-025 Any other dev SHALL go to ISSUE with i2c_dev=dev, i2c_reg=reg, i2c_wdata=val, i2c_rd=0.
REQ-026 i2c_req SHALL assert in ISSUE and stay high with fields stable until the cycle after i2c_done; then WAIT is entered.
REQ-027 i2c_done with nack=0 SHALL go to RB_ISSUE when readback is compiled in, else to NEXT.
REQ-028 A failure (nack=1, or readback mismatch) SHALL increment the retry counter and re-enter ISSUE; after MAX_RETRY retries it SHALL go to FAIL.
REQ-029 The retry counter SHALL clear on entry to each new index.
REQ-030 NEXT SHALL increment lut_index; if lut_index is already all-ones (wrap without terminator) the FSM SHALL go to FAIL instead.
REQ-031 FAIL SHALL set cfg_err=1, err_index=current index, busy=0.
REQ-032 busy SHALL be 1 in all states except IDLE, DONE and FAIL.
REQ-033 start while busy SHALL be ignored.
REQ-034 i2c_done while no request is outstanding SHALL be ignored.

Reset
REQ-035 With rst_n low at a clk edge: i2c_req=0, i2c_rd=0, i2c_dev/reg/wdata=0, lut_index=0, busy=0, cfg_done=0, cfg_err=0, err_index=0, all counters=0, state=IDLE.
REQ-036 After release the FSM SHALL enter PWR on the next edge.
REQ-037 Reset mid-transfer SHALL drop i2c_req at that edge; any late i2c_done SHALL be ignored.

Configuration
REQ-038 Macro CFG_READBACK_EN defined: after each successful write, RB_ISSUE SHALL issue the same dev/reg with i2c_rd=1; i2c_rdata != val or nack SHALL count as a failure.
REQ-039 Macro CFG_READBACK_EN undefined: the RB states SHALL be absent, i2c_rd SHALL be constant 0, and i2c_rdata SHALL be unused.

Verification
REQ-040 Bench SHALL cover: table {78_3008_82, FF}, PWR_WAIT=4, always ACK -> one write (dev 78, reg 3008, data 82); cfg_done=1 at index 1.
REQ-041 Bench SHALL cover: entry FE_0003_00 with DLY_UNIT=10 -> 30 idle cycles with i2c_req=0 between surrounding writes.
REQ-042 Bench SHALL cover: NACK on index 5 twice, then ACK -> 3 requests for index 5, then normal completion.
REQ-043 Bench SHALL cover: NACK on index 7 forever, MAX_RETRY=3 -> 4 requests; cfg_err=1, err_index=7.
REQ-044 Bench SHALL cover: CFG_READBACK_EN with i2c_rdata=val^1 -> FAIL after 4 write+read pairs; without the macro -> i2c_rd never 1.
REQ-045 Bench SHALL cover: rst_n low for one edge mid-WAIT -> i2c_req=0 on that edge; restart from index 0.
